// File: rtl/riscv_hwlp_pkg.sv
//------------------------------------------------------------------------------
// Module      : riscv_hwlp_pkg
// Description : Shared constants for the hardware-loop unit.
//               - Bit positions inside the {cnt,end,start} write-enable vector.
//               - Encodings of the readback select.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package riscv_hwlp_pkg;

    // Bit positions inside hwlp_we_i
    localparam int HWLP_WE_START = 0;
    localparam int HWLP_WE_END   = 1;
    localparam int HWLP_WE_CNT   = 2;

    // Readback select encodings
    localparam logic [1:0] HWLP_RD_START = 2'd0;
    localparam logic [1:0] HWLP_RD_END   = 2'd1;
    localparam logic [1:0] HWLP_RD_CNT   = 2'd2;
    localparam logic [1:0] HWLP_RD_ZERO  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/riscv_hwlp_prio_sel.sv
//------------------------------------------------------------------------------
// Module      : riscv_hwlp_prio_sel
// Description : Find-first-set encoder. Index 0 has the highest priority.
// Ports       : req_i   - request vector, one bit per loop
//               found_o - at least one request bit is set
//               idx_o   - index of the lowest set bit (0 when none)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module riscv_hwlp_prio_sel #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scanning from the top down lets the lowest set bit overwrite the result.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/riscv_hwloop_unit.sv
//------------------------------------------------------------------------------
// Module      : riscv_hwloop_unit
// Description : N-loop hardware-loop unit. It holds the per-loop start, end and
//               counter registers, detects the end address, selects the
//               innermost jumping loop and decrements the counters.
// Ports       : current_pc_i / id_valid_i   - ID-stage PC and advance strobe
//               hwlp_we_i / hwlp_regid_i / hwlp_*_data_i - register write port
//               hwlp_rd_regid_i / hwlp_rd_sel_i / hwlp_rdata_o - readback
//               hwlp_jump_o / hwlp_targ_addr_o / hwlp_loop_id_o - jump request
//               hwlp_err_clr_i / hwlp_err_o - sticky configuration error
// Options     : RISCV_HWLP_ERR_EN - flag a selected loop with start > end,
//               suppress its jump and its decrements.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module riscv_hwloop_unit
    import riscv_hwlp_pkg::*;
#(
    parameter  int N_LOOPS = 2,
    parameter  int ADDR_W  = 32,
    parameter  int CNT_W   = 32,
    localparam int IDX_W   = (N_LOOPS > 1) ? $clog2(N_LOOPS) : 1,
    localparam int DATA_W  = (ADDR_W > CNT_W) ? ADDR_W : CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] current_pc_i,
    input  logic              id_valid_i,
    input  logic [2:0]        hwlp_we_i,
    input  logic [IDX_W-1:0]  hwlp_regid_i,
    input  logic [ADDR_W-1:0] hwlp_start_data_i,
    input  logic [ADDR_W-1:0] hwlp_end_data_i,
    input  logic [CNT_W-1:0]  hwlp_cnt_data_i,
    input  logic [IDX_W-1:0]  hwlp_rd_regid_i,
    input  logic [1:0]        hwlp_rd_sel_i,
    output logic [DATA_W-1:0] hwlp_rdata_o,
    output logic              hwlp_jump_o,
    output logic [ADDR_W-1:0] hwlp_targ_addr_o,
    output logic [IDX_W-1:0]  hwlp_loop_id_o,
    input  logic              hwlp_err_clr_i,
    output logic              hwlp_err_o
);

    logic [ADDR_W-1:0]  r_start [N_LOOPS];
    logic [ADDR_W-1:0]  r_end   [N_LOOPS];
    logic [CNT_W-1:0]   r_cnt   [N_LOOPS];

    logic [N_LOOPS-1:0] w_match;
    logic [N_LOOPS-1:0] w_cand;
    logic [N_LOOPS-1:0] w_exit;
    logic [N_LOOPS-1:0] w_wr_sel;
    logic [N_LOOPS-1:0] w_dec;
    logic               w_found;
    logic [IDX_W-1:0]   w_sel_idx;
    logic [ADDR_W-1:0]  w_sel_start;
    logic               w_cfg_err;
    logic               w_jump;
    logic               w_dec_en;

    // A zero counter disables the loop entirely; count 1 means "last pass".
    generate
        for (genvar l = 0; l < N_LOOPS; l++) begin : g_loop
            assign w_match[l]  = (current_pc_i == r_end[l]) && (r_cnt[l] != '0);
            assign w_cand[l]   = w_match[l] && (r_cnt[l] > CNT_W'(1));
            assign w_exit[l]   = w_match[l] && (r_cnt[l] == CNT_W'(1));
            assign w_wr_sel[l] = (hwlp_regid_i == IDX_W'(l));
        end
    endgenerate

    riscv_hwlp_prio_sel #(
        .N     (N_LOOPS),
        .IDX_W (IDX_W)
    ) u_prio_sel (
        .req_i   (w_cand),
        .found_o (w_found),
        .idx_o   (w_sel_idx)
    );

    assign w_sel_start = r_start[w_sel_idx];

`ifdef RISCV_HWLP_ERR_EN
    logic [ADDR_W-1:0] w_sel_end;
    logic              r_err;

    assign w_sel_end = r_end[w_sel_idx];
    assign w_cfg_err = w_found && (w_sel_start > w_sel_end);

    // Set has priority over clear so an error seen during a clear is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_cfg_err) begin
            r_err <= 1'b1;
        end else if (hwlp_err_clr_i) begin
            r_err <= 1'b0;
        end
    end

    assign hwlp_err_o = r_err;
`else
    logic w_unused_err_clr;

    assign w_cfg_err        = 1'b0;
    assign w_unused_err_clr = hwlp_err_clr_i;
    assign hwlp_err_o       = 1'b0;
`endif

    assign w_jump           = w_found && !w_cfg_err;
    assign hwlp_jump_o      = w_jump;
    assign hwlp_targ_addr_o = w_jump ? w_sel_start : '0;
    assign hwlp_loop_id_o   = w_jump ? w_sel_idx : '0;

    // Decrement set: the jumping loop plus every inner loop leaving on this
    // same end address. With no jumping loop, every exiting loop retires.
    always_comb begin
        w_dec = '0;
        for (int l = 0; l < N_LOOPS; l++) begin
            if (w_found) begin
                if (IDX_W'(l) == w_sel_idx) begin
                    w_dec[l] = 1'b1;
                end else if (IDX_W'(l) < w_sel_idx) begin
                    w_dec[l] = w_exit[l];
                end
            end else begin
                w_dec[l] = w_exit[l];
            end
        end
    end

    assign w_dec_en = id_valid_i && !w_cfg_err;

    // A register write to the counter overrides a same-cycle decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < N_LOOPS; l++) begin
                r_start[l] <= '0;
                r_end[l]   <= '0;
                r_cnt[l]   <= '0;
            end
        end else begin
            for (int l = 0; l < N_LOOPS; l++) begin
                if (w_wr_sel[l] && hwlp_we_i[HWLP_WE_START]) begin
                    r_start[l] <= hwlp_start_data_i;
                end
                if (w_wr_sel[l] && hwlp_we_i[HWLP_WE_END]) begin
                    r_end[l] <= hwlp_end_data_i;
                end
                if (w_wr_sel[l] && hwlp_we_i[HWLP_WE_CNT]) begin
                    r_cnt[l] <= hwlp_cnt_data_i;
                end else if (w_dec_en && w_dec[l]) begin
                    r_cnt[l] <= r_cnt[l] - CNT_W'(1);
                end
            end
        end
    end

    // An index with no matching loop falls through to zero.
    always_comb begin
        hwlp_rdata_o = '0;
        for (int l = 0; l < N_LOOPS; l++) begin
            if (hwlp_rd_regid_i == IDX_W'(l)) begin
                case (hwlp_rd_sel_i)
                    HWLP_RD_START: hwlp_rdata_o = DATA_W'(r_start[l]);
                    HWLP_RD_END:   hwlp_rdata_o = DATA_W'(r_end[l]);
                    HWLP_RD_CNT:   hwlp_rdata_o = DATA_W'(r_cnt[l]);
                    default:       hwlp_rdata_o = '0;
                endcase
            end
        end
    end

endmodule

`default_nettype wire
